// File: rtl/count_frame_tx.sv
// Snapshots four 16-bit pulse counts on request and streams them as a 10-byte
// frame (header, eight count bytes MSB first, 8-bit additive checksum) over valid/ready.
module count_frame_tx #(
    parameter logic [7:0] HEADER_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] count1,
    input  logic [15:0] count2,
    input  logic [15:0] count3,
    input  logic [15:0] count4,
    input  logic        snap,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun
);

    // Handshake: a byte moves on a rising edge with tx_valid=1 and tx_ready=1;
    // tx_valid and tx_data are pure functions of registered state, so they hold
    // steady through any number of tx_ready=0 cycles.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2,
        CHECK  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [63:0] snap_q, snap_d;
    logic        frame_done_q, frame_done_d;
    logic        overrun_q, overrun_d;
    logic [7:0]  data_byte;
    logic [7:0]  checksum;

    assign tx_valid   = (state_q != IDLE);
    assign busy       = (state_q != IDLE);
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

    // snap_q is {count1, count2, count3, count4}, so index 0 is count1[15:8].
    always_comb begin
        data_byte = 8'h00;
        case (idx_q)
            3'd0: data_byte = snap_q[63:56];
            3'd1: data_byte = snap_q[55:48];
            3'd2: data_byte = snap_q[47:40];
            3'd3: data_byte = snap_q[39:32];
            3'd4: data_byte = snap_q[31:24];
            3'd5: data_byte = snap_q[23:16];
            3'd6: data_byte = snap_q[15:8];
            3'd7: data_byte = snap_q[7:0];
            default: data_byte = 8'h00;
        endcase
    end

    always_comb begin
        checksum = 8'h00;
        for (int i = 0; i < 8; i++) begin
            checksum = checksum + snap_q[i*8 +: 8];
        end
    end

    always_comb begin
        tx_data = 8'h00;
        case (state_q)
            HEADER:  tx_data = HEADER_BYTE;
            DATA:    tx_data = data_byte;
            CHECK:   tx_data = checksum;
            default: tx_data = 8'h00;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        snap_d       = snap_q;
        frame_done_d = 1'b0;
        overrun_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (snap) begin
                    snap_d  = {count1, count2, count3, count4};
                    state_d = HEADER;
                end
            end
            HEADER: begin
                if (tx_ready) begin
                    state_d = DATA;
                    idx_d   = 3'd0;
                end
            end
            DATA: begin
                if (tx_ready) begin
                    if (idx_q == 3'd7) begin
                        state_d = CHECK;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            CHECK: begin
                if (tx_ready) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // A request that lands mid-frame, even on the checksum transfer, is dropped.
        if (snap && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= 3'd0;
            snap_q       <= 64'h0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            snap_q       <= snap_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

endmodule

// File: tb/tb_count_frame_tx.sv
// Bench for count_frame_tx: directed scenarios plus randomized frames checked
// against a frame model built from the counts with plain arithmetic.
module tb_count_frame_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] count1, count2, count3, count4;
    logic        snap;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        busy;
    logic        frame_done;
    logic        overrun;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    count_frame_tx #(.HEADER_BYTE(8'hA5)) dut (
        .clk        (clk),
        .rst        (rst),
        .count1     (count1),
        .count2     (count2),
        .count3     (count3),
        .count4     (count4),
        .snap       (snap),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Reference frame: header, each count high byte then low byte, sum of count bytes mod 256.
    task automatic build_frame(input logic [15:0] c1, c2, c3, c4);
        int sum;
        logic [15:0] c[4];
        c[0] = c1; c[1] = c2; c[2] = c3; c[3] = c4;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        sum = 0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'(c[i] / 256));
            exp_q.push_back(8'(c[i] % 256));
            sum = sum + int'(c[i] / 256) + int'(c[i] % 256);
        end
        exp_q.push_back(8'(sum % 256));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse snap for one cycle with the given counts; returns 1 time unit after the edge.
    task automatic do_snap(input logic [15:0] c1, c2, c3, c4);
        count1 = c1; count2 = c2; count3 = c3; count4 = c4;
        snap = 1'b1;
        tick();
        snap = 1'b0;
    endtask

    // Receive bytes until 10 transfers occur. mode 0: ready always 1,
    // mode 1: ready 1/0 alternating starting at 1, mode 2: random ready.
    task automatic collect_frame(input int mode, output int vcycles,
                                 output bit stable_ok, output bit timed_out);
        logic [7:0] prev_data;
        bit         prev_stall;
        int         cyc;
        got_q.delete();
        vcycles    = 0;
        stable_ok  = 1'b1;
        timed_out  = 1'b0;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        cyc        = 0;
        while (got_q.size() < 10) begin
            if (cyc > 300) begin
                timed_out = 1'b1;
                break;
            end
            case (mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = (cyc % 2 == 0);
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
            if (prev_stall && (tx_data !== prev_data || tx_valid !== 1'b1)) stable_ok = 1'b0;
            if (tx_valid === 1'b1) vcycles++;
            if (tx_valid === 1'b1 && tx_ready) got_q.push_back(tx_data);
            prev_stall = (tx_valid === 1'b1) && !tx_ready;
            prev_data  = tx_data;
            tick();
            cyc++;
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; snap = 1'b0; tx_ready = 1'b1;
        count1 = 16'h1111; count2 = 16'h2222; count3 = 16'h3333; count4 = 16'h4444;
        tick(); tick();
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%0b want=0", tx_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%0b want=0", frame_done); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%0b want=0", overrun); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%02h want=00", tx_data); end
        rst = 1'b0;
        tick();
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL idle_ready_no_effect got=%0b want=0", tx_valid); end
        tx_ready = 1'b0;
    endtask

    task automatic test_basic();
        int vc; bit st, to;
        build_frame(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
        do_snap(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
        total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL basic_latency got=%0b want=1", tx_valid); end
        collect_frame(0, vc, st, to);
        total++; if (to) begin bad++; $display("FAIL basic_timeout got=%0d want=10 bytes", got_q.size()); end
        total++; if (vc !== 10) begin bad++; $display("FAIL basic_valid_cycles got=%0d want=10", vc); end
        for (int i = 0; i < 10; i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL basic_byte%0d got=%02h want=%02h", i, got_q[i], exp_q[i]); end
        end
        total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL basic_frame_done got=%0b want=1", frame_done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done got=%0b want=0", busy); end
        tick();
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL basic_done_width got=%0b want=0", frame_done); end
    endtask

    task automatic test_backpressure();
        int vc; bit st, to;
        build_frame(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        do_snap(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        collect_frame(1, vc, st, to);
        total++; if (to) begin bad++; $display("FAIL bp_timeout got=%0d want=10 bytes", got_q.size()); end
        total++; if (vc !== 19) begin bad++; $display("FAIL bp_valid_cycles got=%0d want=19", vc); end
        total++; if (st !== 1'b1) begin bad++; $display("FAIL bp_stable got=%0b want=1", st); end
        for (int i = 0; i < 10; i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_byte%0d got=%02h want=%02h", i, got_q[i], exp_q[i]); end
        end
        total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL bp_frame_done got=%0b want=1", frame_done); end
        tick();
    endtask

    task automatic test_zero_and_change();
        int vc; bit st, to;
        build_frame(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        do_snap(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        count1 = 16'h0001; count2 = 16'h0001; count3 = 16'h0001; count4 = 16'h0001;
        collect_frame(0, vc, st, to);
        total++; if (to) begin bad++; $display("FAIL zero_timeout got=%0d want=10 bytes", got_q.size()); end
        for (int i = 0; i < 10; i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL zero_byte%0d got=%02h want=%02h", i, got_q[i], exp_q[i]); end
        end
        tick();
    endtask

    task automatic test_overrun();
        int vc, ov_cnt; bit st, to;
        build_frame(16'hCAFE, 16'h0102, 16'h8000, 16'h7FFF);
        do_snap(16'hCAFE, 16'h0102, 16'h8000, 16'h7FFF);
        got_q.delete();
        ov_cnt = 0;
        tx_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (overrun === 1'b1) ov_cnt++;
            if (k == 5) begin
                total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_mid_pulse got=%0b want=1", overrun); end
            end
            if (tx_valid === 1'b1) got_q.push_back(tx_data);
            snap = (k == 4 || k == 9);
            tick();
            snap = 1'b0;
        end
        if (overrun === 1'b1) ov_cnt++;
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_check_pulse got=%0b want=1", overrun); end
        total++; if (ov_cnt !== 2) begin bad++; $display("FAIL ovr_pulse_count got=%0d want=2", ov_cnt); end
        total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL ovr_frame_done got=%0b want=1", frame_done); end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL ovr_no_second_frame got=%0b want=0", tx_valid); end
        for (int i = 0; i < 10; i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL ovr_byte%0d got=%02h want=%02h", i, got_q[i], exp_q[i]); end
        end
        // Snap in the frame_done cycle starts a frame immediately.
        build_frame(16'h0F0F, 16'hF0F0, 16'h00FF, 16'hFF00);
        do_snap(16'h0F0F, 16'hF0F0, 16'h00FF, 16'hFF00);
        total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL b2b_start got=%0b want=1", tx_valid); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_no_overrun got=%0b want=0", overrun); end
        collect_frame(0, vc, st, to);
        for (int i = 0; i < 10; i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_byte%0d got=%02h want=%02h", i, got_q[i], exp_q[i]); end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int vc; bit st, to;
        do_snap(16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD);
        tx_ready = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tx_ready = 1'b0;
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rmid_tx_valid got=%0b want=0", tx_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%0b want=0", busy); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rmid_tx_data got=%02h want=00", tx_data); end
        for (int k = 0; k < 3; k++) begin
            total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rmid_no_done got=%0b want=0", frame_done); end
            tick();
        end
        // Reset wins over a coincident snap, from idle and from mid-frame.
        rst = 1'b1; snap = 1'b1;
        tick();
        rst = 1'b0; snap = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rsnap_idle_busy got=%0b want=0", busy); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rsnap_idle_overrun got=%0b want=0", overrun); end
        do_snap(16'h1, 16'h2, 16'h3, 16'h4);
        rst = 1'b1; snap = 1'b1;
        tick();
        rst = 1'b0; snap = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rsnap_busy_busy got=%0b want=0", busy); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rsnap_busy_overrun got=%0b want=0", overrun); end
        build_frame(16'h0102, 16'h0304, 16'h0506, 16'h0708);
        do_snap(16'h0102, 16'h0304, 16'h0506, 16'h0708);
        collect_frame(0, vc, st, to);
        for (int i = 0; i < 10; i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rmid_after_byte%0d got=%02h want=%02h", i, got_q[i], exp_q[i]); end
        end
        tick();
    endtask

    task automatic test_random();
        int vc, gap; bit st, to;
        logic [15:0] c1, c2, c3, c4;
        for (int f = 0; f < 15; f++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rnd_idle f=%0d got=%0b want=0", f, tx_valid); end
                tx_ready = 1'($urandom_range(0, 1));
                count1 = 16'($urandom); count2 = 16'($urandom);
                tick();
            end
            c1 = 16'($urandom); c2 = 16'($urandom); c3 = 16'($urandom); c4 = 16'($urandom);
            build_frame(c1, c2, c3, c4);
            do_snap(c1, c2, c3, c4);
            count1 = 16'($urandom); count2 = 16'($urandom); count3 = 16'($urandom); count4 = 16'($urandom);
            collect_frame(2, vc, st, to);
            total++; if (to) begin bad++; $display("FAIL rnd_timeout f=%0d got=%0d want=10 bytes", f, got_q.size()); end
            total++; if (st !== 1'b1) begin bad++; $display("FAIL rnd_stable f=%0d got=%0b want=1", f, st); end
            for (int i = 0; i < 10; i++) begin
                total++;
                if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rnd_f%0d_byte%0d got=%02h want=%02h", f, i, got_q[i], exp_q[i]); end
            end
            total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL rnd_done f=%0d got=%0b want=1", f, frame_done); end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; snap = 1'b0; tx_ready = 1'b0;
        count1 = 16'h0; count2 = 16'h0; count3 = 16'h0; count4 = 16'h0;
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_and_change();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/count_frame_tx.md
COUNT_FRAME_TX -- requirements
Module: count_frame_tx

Interface
REQ-001 Parameter: HEADER_BYTE, 8'hA5, first byte of every frame.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 count1  input  16  channel 1 pulse count from the four-channel counter stage.
REQ-006 count2  input  16  channel 2 pulse count.
REQ-007 count3  input  16  channel 3 pulse count.
REQ-008 count4  input  16  channel 4 pulse count.
REQ-009 snap  input  1  single-cycle request to capture all four counts and transmit one frame.
REQ-010 tx_ready  input  1  downstream byte sink ready.
REQ-011 tx_data  output  8  current frame byte.
REQ-012 tx_valid  output  1  tx_data holds a valid byte.
REQ-013 busy  output  1  high whenever a frame is in progress (state not IDLE).
REQ-014 frame_done  output  1  one-cycle pulse after the checksum byte is accepted.
REQ-015 overrun  output  1  one-cycle pulse when snap arrives while busy.

Function
REQ-016 The block SHALL use FSM states IDLE, HEADER, DATA, CHECK; 3-bit byte index in DATA selects 0..7.
REQ-017 The block SHALL capture count1..count4 into a 64-bit snapshot register on the edge where snap=1 and state=IDLE, then enter HEADER; all four counts are taken from the same cycle.
REQ-018 Frame order SHALL be: HEADER_BYTE, count1[15:8], count1[7:0], count2[15:8], count2[7:0], count3[15:8], count3[7:0], count4[15:8], count4[7:0], checksum (10 bytes).
REQ-019 Checksum SHALL be the 8-bit sum, modulo 256, of the 8 count bytes (header excluded), computed from the snapshot.
REQ-020 A byte SHALL transfer on a rising edge where tx_valid=1 and tx_ready=1; the FSM advances exactly one byte per transfer.
REQ-021 While tx_valid=1 and tx_ready=0, tx_data and tx_valid SHALL hold unchanged; tx_valid never drops before its transfer.
REQ-022 tx_valid SHALL be 1 in HEADER, DATA, CHECK and 0 in IDLE; first byte is valid in the cycle after snap is accepted (latency 1).
REQ-023 With tx_ready held 1, a frame SHALL occupy exactly 10 consecutive cycles of tx_valid=1.
REQ-024 DATA SHALL leave for CHECK on the transfer of index 7; CHECK returns to IDLE on its transfer.
REQ-025 frame_done SHALL be 1 for exactly the cycle following the checksum transfer; busy=0 in that cycle.
REQ-026 A snap in the frame_done cycle SHALL be accepted (state is IDLE).
REQ-027 A snap while busy=1, including the cycle of the checksum transfer, SHALL be ignored and overrun SHALL pulse 1 in the next cycle; the frame in flight is unaffected.
REQ-028 Counts changing after capture SHALL NOT affect the frame in flight.
REQ-029 tx_ready asserted while tx_valid=0 SHALL have no effect.

Reset
REQ-030 On rst=1 at a rising edge, the FSM SHALL go to IDLE and tx_valid, busy, frame_done, overrun SHALL be 0 and tx_data 8'h00 from the next cycle.
REQ-031 Reset mid-frame SHALL abort the frame with no frame_done pulse; snapshot contents are don't-care.
REQ-032 rst SHALL take priority over snap in the same cycle: snap ignored, no overrun.

Verification
REQ-033 Counts 0x1234, 0x5678, 0x9ABC, 0xDEF0, snap, tx_ready=1 -> bytes A5 12 34 56 78 9A BC DE F0 38 on 10 consecutive cycles, then frame_done=1 for 1 cycle.
REQ-034 All counts 0xFFFF, tx_ready toggling 1/0 each cycle -> same 10-byte order ending in checksum F8, tx_data stable through every ready=0 cycle, 19 cycles total.
REQ-035 All counts 0x0000 -> A5, eight 00, checksum 00; counts changed to 0x0001 during the frame -> frame unchanged.
REQ-036 Snap during byte 4, and snap coincident with checksum transfer -> overrun pulses once each, no second frame; snap in the frame_done cycle -> new frame begins the next cycle.
REQ-037 rst=1 while sending byte 6 -> tx_valid=0 and busy=0 next cycle, no frame_done; a following snap -> full frame starting with A5.
